// File: rtl/gpio_port_out_if.sv
// I/O-space bus between the core and one GPIO port's register block.
// Read data and its bus-drive enable are combinational from the slave; writes take effect on the clock edge.
// There is no backpressure: every strobe is accepted in the cycle it is presented.
interface gpio_port_out_if;
  logic [5:0] io_addr;
  logic       io_wr_en;
  logic       io_rd_en;
  logic [7:0] io_dbus_in;
  logic [7:0] io_dbus_out;
  logic       io_out_en;

  modport master (
    output io_addr, io_wr_en, io_rd_en, io_dbus_in,
    input  io_dbus_out, io_out_en
  );

  modport slave (
    input  io_addr, io_wr_en, io_rd_en, io_dbus_in,
    output io_dbus_out, io_out_en
  );
endinterface

// File: rtl/gpio_port_out.sv
// GPIO port output side: DDRx/PORTx registers, PINx write-1-toggle, alternate-function pad mux, pull-up control.
// Latency: reg write->pads 1 clk, pud/alt->pads comb; with GPIO_OUT_REG_EN defined, 2 clk and 1 clk respectively.
// No backpressure: I/O reads are combinational and writes are always accepted on the strobe edge.
module gpio_port_out #(
  parameter int         p_width     = 8,
  parameter logic [5:0] p_pin_addr  = 6'h03,
  parameter logic [5:0] p_ddr_addr  = 6'h04,
  parameter logic [5:0] p_port_addr = 6'h05
) (
  input  logic               clk,
  input  logic               nrst,
  gpio_port_out_if.slave     io,
  input  logic [p_width-1:0] pin_sync,
  input  logic               pud,
  input  logic [p_width-1:0] alt_en,
  input  logic [p_width-1:0] alt_out,
  input  logic [p_width-1:0] alt_oe,
  output logic [p_width-1:0] pad_out,
  output logic [p_width-1:0] pad_oe,
  output logic [p_width-1:0] pad_pue
);

  logic [p_width-1:0] ddr_q, ddr_d;
  logic [p_width-1:0] port_q, port_d;
  logic [p_width-1:0] wr_dat;
  logic               hit_pin, hit_ddr, hit_port;
  logic               rd_hit;
  logic [7:0]         rd_dat;
  logic [p_width-1:0] mux_out, mux_oe, mux_pue;

  assign hit_pin  = (io.io_addr == p_pin_addr);
  assign hit_ddr  = (io.io_addr == p_ddr_addr);
  assign hit_port = (io.io_addr == p_port_addr);
  // Bus bits above the port width are simply dropped.
  assign wr_dat   = io.io_dbus_in[p_width-1:0];

  // Next register values: direct loads for DDR/PORT, write-1-toggle of PORT via PIN.
  always_comb begin
    ddr_d  = ddr_q;
    port_d = port_q;
    if (io.io_wr_en) begin
      if (hit_ddr) begin
        ddr_d = wr_dat;
      end
      if (hit_port) begin
        port_d = wr_dat;
      end else if (hit_pin) begin
        port_d = port_q ^ wr_dat;
      end
    end
  end

  // Register state; reset wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ddr_q  <= '0;
      port_q <= '0;
    end else begin
      ddr_q  <= ddr_d;
      port_q <= port_d;
    end
  end

  // Combinational readback; a same-cycle write is not yet visible here.
  always_comb begin
    rd_dat = '0;
    rd_hit = io.io_rd_en & (hit_pin | hit_ddr | hit_port);
    if (rd_hit) begin
      if (hit_pin) begin
        rd_dat[p_width-1:0] = pin_sync;
      end else if (hit_ddr) begin
        rd_dat[p_width-1:0] = ddr_q;
      end else begin
        rd_dat[p_width-1:0] = port_q;
      end
    end
  end

  assign io.io_dbus_out = rd_dat;
  assign io.io_out_en   = rd_hit;

  // Per-bit pad mux: alternate function overrides PORT/DDR; pull-up only on undriven pins with PORT=1.
  always_comb begin
    mux_out = (alt_en & alt_out) | (~alt_en & port_q);
    mux_oe  = (alt_en & alt_oe)  | (~alt_en & ddr_q);
    mux_pue = ~mux_oe & port_q & {p_width{~pud}};
  end

`ifdef GPIO_OUT_REG_EN
  logic [p_width-1:0] pad_out_q, pad_out_d;
  logic [p_width-1:0] pad_oe_q, pad_oe_d;
  logic [p_width-1:0] pad_pue_q, pad_pue_d;

  // Retime the mux result so the pads only change on clock edges.
  always_comb begin
    pad_out_d = mux_out;
    pad_oe_d  = mux_oe;
    pad_pue_d = mux_pue;
  end

  // Pad output flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
      pad_pue_q <= '0;
    end else begin
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
      pad_pue_q <= pad_pue_d;
    end
  end

  assign pad_out = pad_out_q;
  assign pad_oe  = pad_oe_q;
  assign pad_pue = pad_pue_q;
`else
  assign pad_out = mux_out;
  assign pad_oe  = mux_oe;
  assign pad_pue = mux_pue;
`endif

endmodule

// File: tb/tb_gpio_port_out.sv
// Self-checking bench for gpio_port_out: expectations are queued as stimulus is applied and checked when outputs settle.
// Pad checks wait one extra clock when GPIO_OUT_REG_EN is defined.
// The bus never stalls, so every check is taken at a fixed point after the stimulus.
module tb_gpio_port_out;

  localparam logic [5:0] PIN_A  = 6'h03;
  localparam logic [5:0] DDR_A  = 6'h04;
  localparam logic [5:0] PORT_A = 6'h05;

  localparam int SEL_OUT = 0, SEL_OE = 1, SEL_PUE = 2, SEL_DBUS = 3, SEL_OUTEN = 4;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       nrst;
  logic [7:0] pin_sync;
  logic       pud;
  logic [7:0] alt_en, alt_out, alt_oe;
  logic [7:0] pad_out, pad_oe, pad_pue;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  gpio_port_out_if io ();

  gpio_port_out #(
    .p_width    (8),
    .p_pin_addr (PIN_A),
    .p_ddr_addr (DDR_A),
    .p_port_addr(PORT_A)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .io      (io.slave),
    .pin_sync(pin_sync),
    .pud     (pud),
    .alt_en  (alt_en),
    .alt_out (alt_out),
    .alt_oe  (alt_oe),
    .pad_out (pad_out),
    .pad_oe  (pad_oe),
    .pad_pue (pad_pue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_OUT:   observe = pad_out;
      SEL_OE:    observe = pad_oe;
      SEL_PUE:   observe = pad_pue;
      SEL_DBUS:  observe = io.io_dbus_out;
      default:   observe = {7'b0, io.io_out_en};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic settle();
`ifdef GPIO_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io.io_addr    = a;
    io.io_dbus_in = d;
    io.io_wr_en   = 1'b1;
    @(posedge clk);
    #1;
    io.io_wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    io.io_addr  = a;
    io.io_rd_en = 1'b1;
    push(tag, SEL_DBUS, exp);
    push({tag, "_en"}, SEL_OUTEN, 8'h01);
    #1;
    drain();
    io.io_rd_en = 1'b0;
  endtask

  task automatic pad_chk(input string tag, input logic [7:0] e_out, input logic [7:0] e_oe,
                         input logic [7:0] e_pue);
    push({tag, "_out"}, SEL_OUT, e_out);
    push({tag, "_oe"},  SEL_OE,  e_oe);
    push({tag, "_pue"}, SEL_PUE, e_pue);
    settle();
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst          = 1'b0;
    pin_sync      = 8'h00;
    pud           = 1'b0;
    alt_en        = 8'h00;
    alt_out       = 8'h00;
    alt_oe        = 8'h00;
    io.io_addr    = 6'h00;
    io.io_wr_en   = 1'b0;
    io.io_rd_en   = 1'b0;
    io.io_dbus_in = 8'h00;

    // Reset state
    @(posedge clk);
    #1;
    nrst = 1'b1;
    pad_chk("rst", 8'h00, 8'h00, 8'h00);
    push("rst_idle_en", SEL_OUTEN, 8'h00);
    push("rst_idle_dbus", SEL_DBUS, 8'h00);
    #1;
    drain();
    rd_chk("rst_ddr", DDR_A, 8'h00);
    rd_chk("rst_port", PORT_A, 8'h00);

    // Direct register writes drive the pads
    wr(DDR_A, 8'hF0);
    wr(PORT_A, 8'hA5);
    pad_chk("wr", 8'hA5, 8'hF0, 8'h05);
    rd_chk("wr_ddr", DDR_A, 8'hF0);
    rd_chk("wr_port", PORT_A, 8'hA5);

    // PINx write toggles PORT bits, leaves DDR alone
    wr(PIN_A, 8'h0F);
    rd_chk("tog1_port", PORT_A, 8'hAA);
    rd_chk("tog1_ddr", DDR_A, 8'hF0);
    wr(PIN_A, 8'h0F);
    rd_chk("tog2_port", PORT_A, 8'hA5);

    // Foreign address: no state change, no bus drive
    wr(6'h06, 8'hFF);
    rd_chk("foreign_port", PORT_A, 8'hA5);
    rd_chk("foreign_ddr", DDR_A, 8'hF0);
    io.io_addr  = 6'h06;
    io.io_rd_en = 1'b1;
    push("foreign_rd_en", SEL_OUTEN, 8'h00);
    push("foreign_rd_dbus", SEL_DBUS, 8'h00);
    #1;
    drain();
    io.io_rd_en = 1'b0;

    // Read and write PORT in the same cycle
    io.io_addr    = PORT_A;
    io.io_dbus_in = 8'h11;
    io.io_wr_en   = 1'b1;
    io.io_rd_en   = 1'b1;
    push("rw_old", SEL_DBUS, 8'hA5);
    #1;
    drain();
    @(posedge clk);
    #1;
    io.io_wr_en = 1'b0;
    push("rw_new", SEL_DBUS, 8'h11);
    #1;
    drain();
    io.io_rd_en = 1'b0;
    pad_chk("rw_pad", 8'h11, 8'hF0, 8'h01);

    // Global pull-up disable
    wr(DDR_A, 8'h00);
    wr(PORT_A, 8'hFF);
    pud = 1'b1;
    push("pud1_pue", SEL_PUE, 8'h00);
    settle();
    drain();
    pud = 1'b0;
    push("pud0_pue", SEL_PUE, 8'hFF);
    settle();
    drain();

    // Alternate-function override on bit 0
    wr(PORT_A, 8'h00);
    alt_en  = 8'h01;
    alt_oe  = 8'h01;
    alt_out = 8'h01;
    pad_chk("alt1", 8'h01, 8'h01, 8'h00);

    // Override with alt_oe=0 on a PORT=1 bit still gets the pull-up
    wr(DDR_A, 8'h01);
    wr(PORT_A, 8'h03);
    alt_en  = 8'h03;
    alt_oe  = 8'h02;
    alt_out = 8'h02;
    pad_chk("alt2", 8'h02, 8'h02, 8'h01);
    alt_en  = 8'h00;
    alt_oe  = 8'h00;
    alt_out = 8'h00;

    // Reset overrides a coincident write
    io.io_addr    = PORT_A;
    io.io_dbus_in = 8'h3C;
    io.io_wr_en   = 1'b1;
    nrst          = 1'b0;
    @(posedge clk);
    #1;
    io.io_wr_en = 1'b0;
    nrst        = 1'b1;
    rd_chk("rstwr_port", PORT_A, 8'h00);
    rd_chk("rstwr_ddr", DDR_A, 8'h00);

    // PIN readback follows pin_sync
    pin_sync = 8'h5A;
    rd_chk("pin_rd", PIN_A, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
